// File: rtl/instruction_fetch.sv
// IF stage of the 5-stage MIPS pipeline: owns the PC, a loader-written instruction memory,
// next-PC selection and the IF/ID register, with stall/enable freeze, jump flush and HALT.
module instruction_fetch #(
  parameter int unsigned        NB_DATA   = 32,
  parameter int unsigned        NB_ADDR   = 8,
  parameter logic [NB_DATA-1:0] HALT_WORD = 32'hFFFFFFFF
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic               i_enable,
  input  logic               i_stall,
  input  logic               i_jump,
  input  logic [NB_DATA-1:0] i_jump_addr,
  input  logic               i_inst_write_enable,
  input  logic [NB_ADDR-1:0] i_inst_write_addr,
  input  logic [NB_DATA-1:0] i_inst_write_data,
  output logic [NB_DATA-1:0] o_pc,
  output logic [NB_DATA-1:0] o_pc4,
  output logic [NB_DATA-1:0] o_instruction,
  output logic               o_halt
);

  typedef enum logic [0:0] {StRun, StHalted} state_e;

  state_e             state;
  logic [NB_DATA-1:0] mem [0:(2**NB_ADDR)-1];
  logic [NB_DATA-1:0] word;
  logic [NB_DATA-1:0] pc_plus4;
  logic [NB_DATA-1:0] jump_target;
  logic               adv;

  // Word-addressed read; PC bits above the memory range alias.
  assign word        = mem[o_pc[NB_ADDR+1:2]];
  assign pc_plus4    = o_pc + NB_DATA'(4);
  assign jump_target = i_jump_addr & ~NB_DATA'(3);
  assign adv         = i_enable & ~i_stall & (state == StRun);

  // Not reset so a loaded program survives a pipeline reset.
  always_ff @(posedge i_clk) begin
    if (i_inst_write_enable) begin
      mem[i_inst_write_addr] <= i_inst_write_data;
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      o_pc          <= '0;
      o_pc4         <= '0;
      o_instruction <= '0;
      o_halt        <= 1'b0;
      state         <= StRun;
    end else begin
      unique case (state)
        StRun: begin
          if (adv) begin
            if (i_jump) begin
              o_pc          <= jump_target;
              o_pc4         <= '0;
              o_instruction <= '0;
            end else if (word == HALT_WORD) begin
              // PC stays on the HALT word; the HALT itself still goes down the pipe.
              o_pc4         <= pc_plus4;
              o_instruction <= HALT_WORD;
              o_halt        <= 1'b1;
              state         <= StHalted;
            end else begin
              o_pc          <= pc_plus4;
              o_pc4         <= pc_plus4;
              o_instruction <= word;
            end
          end
        end
        StHalted: begin
          if (i_enable) begin
            o_pc4         <= '0;
            o_instruction <= '0;
          end
        end
        default: state <= StRun;
      endcase
    end
  end

endmodule
